// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters, holding operands SETTLE cycles.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port0 priority; default build is round-robin.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_m0,
  input  logic [3:0]       req_m1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_y,
  output logic [2:0]       resp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_m,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of,
  output logic             busy
);

  // state  | meaning
  // IDLE   | no operation in flight, arbitration open
  // ISSUE  | operands held on the ALU while it settles
  // RESP   | result registered, waiting for owner handshake
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_m_q, alu_m_d;
  logic [WIDTH-1:0] resp_y_q, resp_y_d;
  logic [2:0]       resp_flags_q, resp_flags_d;
  logic             grant;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_m_q      <= '0;
      resp_y_q     <= '0;
      resp_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_m_q      <= alu_m_d;
      resp_y_q     <= resp_y_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_m_d      = alu_m_q;
    resp_y_d     = resp_y_q;
    resp_flags_d = resp_flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          owner_d = grant;
          cnt_d   = '0;
          alu_a_d = grant ? req_a1 : req_a0;
          alu_b_d = grant ? req_b1 : req_b0;
          alu_m_d = grant ? req_m1 : req_m0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          prio_d  = ~grant;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          resp_y_d     = alu_y;
          resp_flags_d = {alu_zf, alu_cf, alu_of};
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In fixed-priority builds prio_q never leaves 0, so grant falls to port0 on a tie.
  always_comb begin
    grant      = 1'b0;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    unique case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = prio_q;
      default: grant = 1'b0;
    endcase
    if (state_q == S_IDLE && !rst && req_valid[grant]) req_ready[grant] = 1'b1;
    if (state_q == S_RESP) resp_valid[owner_q] = 1'b1;
    accept = |req_ready;
    busy   = (state_q != S_IDLE);
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_m      = alu_m_q;
  assign resp_y     = resp_y_q;
  assign resp_flags = resp_flags_q;

endmodule
